pipe_sched: RTL and testbench

Pipeline scheduler for the 5-stage CPU: consumes the data-hazard flag from the ID-stage hazard checker, branch decode/resolution flags and the data-memory busy flag. It produces every pipeline-register write enable, flush and bubble, plus the PC redirect select. It replaces ad-hoc IF/ID stall wiring with one FSM that owns branch sequencing and a branch-resolution timeout.

---
 rtl/pipe_sched_pkg.sv | 25 ++
 rtl/pipe_sched_satcnt.sv | 23 ++
 rtl/pipe_sched.sv | 136 +++++++++++++
 tb/tb_pipe_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_sched_pkg.sv
// Shared types and constants for the pipeline scheduler: FSM encodings,
// counter widths and the packed control bundle driven to the datapath.
package pipe_sched_pkg;

    localparam int STATE_W        = 2;
    localparam int CNT_W          = 4;
    localparam int PERF_W_DEFAULT = 16;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_BR_WAIT = 2'b01;

    typedef struct packed {
        logic pc_we;
        logic pc_sel_target;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_we;
    } ctl_t;

endpackage

// File: rtl/pipe_sched_satcnt.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module pipe_sched_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_sched.sv
// Pipeline scheduler: owns all pipeline-register enables, flushes, bubbles and
// branch sequencing. Optional perf counters under PIPE_SCHED_PERF_EN.
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter int BR_TIMEOUT = 4,
    parameter int PERF_W     = PERF_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic id_valid,
    input  logic id_branch,
    input  logic id_hazard,
    input  logic ex_br_done,
    input  logic ex_br_taken,
    input  logic mem_busy,
    output logic pc_we,
    output logic pc_sel_target,
    output logic ifid_we,
    output logic ifid_flush,
    output logic idex_we,
    output logic idex_bubble,
    output logic exmem_we,
    output logic memwb_we,
    output logic br_timeout
`ifdef PIPE_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
`endif
);

    // Counter value seen in the last permitted BR_WAIT cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BR_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_br_timeout;
    logic             w_to_set;
    ctl_t             w_ctl;
    ctl_t             w_out;

    always_comb begin
        w_ctl        = '0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_to_set     = 1'b0;
        if (!mem_busy) begin
            case (r_state)
                ST_RUN: begin
                    w_ctl.exmem_we = 1'b1;
                    w_ctl.memwb_we = 1'b1;
                    w_ctl.idex_we  = 1'b1;
                    if (id_valid && id_hazard) begin
                        w_ctl.idex_bubble = 1'b1;
                    end else if (id_valid && id_branch) begin
                        w_ctl.ifid_flush = 1'b1;
                        w_state_next     = ST_BR_WAIT;
                        w_cnt_next       = '0;
                    end else begin
                        w_ctl.pc_we   = 1'b1;
                        w_ctl.ifid_we = 1'b1;
                    end
                end
                ST_BR_WAIT: begin
                    w_ctl.idex_we     = 1'b1;
                    w_ctl.idex_bubble = 1'b1;
                    w_ctl.exmem_we    = 1'b1;
                    w_ctl.memwb_we    = 1'b1;
                    w_cnt_next        = r_cnt + 1'b1;
                    if (ex_br_done) begin
                        w_ctl.pc_we         = 1'b1;
                        w_ctl.pc_sel_target = ex_br_taken;
                        w_ctl.ifid_flush    = 1'b1;
                        w_state_next        = ST_RUN;
                        w_cnt_next          = '0;
                    end else if (r_cnt == TO_LAST) begin
                        // Give up on resolution and continue sequentially.
                        w_ctl.pc_we      = 1'b1;
                        w_ctl.ifid_flush = 1'b1;
                        w_to_set         = 1'b1;
                        w_state_next     = ST_RUN;
                        w_cnt_next       = '0;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_br_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_br_timeout <= r_br_timeout | w_to_set;
        end
    end

    assign w_out = reset ? ctl_t'('0) : w_ctl;

    assign pc_we         = w_out.pc_we;
    assign pc_sel_target = w_out.pc_sel_target;
    assign ifid_we       = w_out.ifid_we;
    assign ifid_flush    = w_out.ifid_flush;
    assign idex_we       = w_out.idex_we;
    assign idex_bubble   = w_out.idex_bubble;
    assign exmem_we      = w_out.exmem_we;
    assign memwb_we      = w_out.memwb_we;
    assign br_timeout    = r_br_timeout;

`ifdef PIPE_SCHED_PERF_EN
    pipe_sched_satcnt #(.W(PERF_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (!w_out.pc_we),
        .o_count (stall_cycles)
    );

    pipe_sched_satcnt #(.W(PERF_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_out.ifid_flush),
        .o_count (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched; perf counters are checked when
// PIPE_SCHED_PERF_EN is defined.
module tb_pipe_sched;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_branch, id_hazard, ex_br_done, ex_br_taken, mem_busy;
    logic pc_we, pc_sel_target, ifid_we, ifid_flush;
    logic idex_we, idex_bubble, exmem_we, memwb_we, br_timeout;
`ifdef PIPE_SCHED_PERF_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // {pc_we, pc_sel_target, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
    logic [7:0] obs;
    assign obs = {pc_we, pc_sel_target, ifid_we, ifid_flush,
                  idex_we, idex_bubble, exmem_we, memwb_we};

    localparam logic [7:0] C_NONE  = 8'h00;
    localparam logic [7:0] C_RUN   = 8'hAB;
    localparam logic [7:0] C_STALL = 8'h0F;
    localparam logic [7:0] C_TAKEN = 8'hDF;
    localparam logic [7:0] C_SEQ   = 8'h9F;

    always #5 clk = ~clk;

    pipe_sched #(.BR_TIMEOUT(4), .PERF_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_branch     (id_branch),
        .id_hazard     (id_hazard),
        .ex_br_done    (ex_br_done),
        .ex_br_taken   (ex_br_taken),
        .mem_busy      (mem_busy),
        .pc_we         (pc_we),
        .pc_sel_target (pc_sel_target),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_we       (idex_we),
        .idex_bubble   (idex_bubble),
        .exmem_we      (exmem_we),
        .memwb_we      (memwb_we),
        .br_timeout    (br_timeout)
`ifdef PIPE_SCHED_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    // Apply one cycle of inputs just after the edge and let them settle.
    task automatic drive(input logic v, input logic br, input logic hz,
                         input logic done, input logic tk, input logic busy);
        id_valid = v; id_branch = br; id_hazard = hz;
        ex_br_done = done; ex_br_taken = tk; mem_busy = busy;
        #2;
        $display("[%0t] in v=%b br=%b hz=%b done=%b tk=%b busy=%b -> ctl=%h to=%b",
                 $time, v, br, hz, done, tk, busy, obs, br_timeout);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1, 1, 1, 1, 1);
        n_cmp++; if (obs !== C_NONE) begin n_err++; $display("FAIL reset_ctl got %h exp %h", obs, C_NONE); end
        tick();
        tick();
        n_cmp++; if (obs !== C_NONE) begin n_err++; $display("FAIL reset_ctl_held got %h exp %h", obs, C_NONE); end
        n_cmp++; if (br_timeout !== 1'b0) begin n_err++; $display("FAIL reset_to got %b exp 0", br_timeout); end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL release_run got %h exp %h", obs, C_RUN); end
        tick();
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL run_after_release got %h exp %h", obs, C_RUN); end
        n_cmp++; if (br_timeout !== 1'b0) begin n_err++; $display("FAIL release_to got %b exp 0", br_timeout); end
    endtask

    task automatic test_hazard();
        tick();
        drive(1, 0, 1, 0, 0, 0);
        n_cmp++; if (obs !== C_STALL) begin n_err++; $display("FAIL hazard_c1 got %h exp %h", obs, C_STALL); end
        tick();
        drive(1, 0, 1, 0, 0, 0);
        n_cmp++; if (obs !== C_STALL) begin n_err++; $display("FAIL hazard_c2 got %h exp %h", obs, C_STALL); end
        tick();
        drive(1, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL hazard_clear got %h exp %h", obs, C_RUN); end
`ifdef PIPE_SCHED_PERF_EN
        n_cmp++; if (stall_cycles !== 16'd2) begin n_err++; $display("FAIL stall_cnt got %0d exp 2", stall_cycles); end
`endif
    endtask

    task automatic test_branch_taken();
        tick();
        drive(1, 1, 0, 0, 0, 0);
        n_cmp++; if ({pc_we, ifid_flush, idex_we, idex_bubble} !== 4'b0110) begin
            n_err++; $display("FAIL br_issue got %b exp 0110", {pc_we, ifid_flush, idex_we, idex_bubble}); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_STALL) begin n_err++; $display("FAIL br_wait got %h exp %h", obs, C_STALL); end
        tick();
        drive(0, 0, 0, 1, 1, 0);
        n_cmp++; if (obs !== C_TAKEN) begin n_err++; $display("FAIL br_taken got %h exp %h", obs, C_TAKEN); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL br_back_run got %h exp %h", obs, C_RUN); end
`ifdef PIPE_SCHED_PERF_EN
        n_cmp++; if (flush_count !== 16'd2) begin n_err++; $display("FAIL flush_cnt got %0d exp 2", flush_count); end
        n_cmp++; if (stall_cycles !== 16'd4) begin n_err++; $display("FAIL stall_cnt2 got %0d exp 4", stall_cycles); end
`endif
    endtask

    task automatic test_busy_in_wait();
        tick();
        drive(1, 1, 0, 0, 0, 0);
        n_cmp++; if (ifid_flush !== 1'b1) begin n_err++; $display("FAIL busy_br_issue flush got %b exp 1", ifid_flush); end
        tick();
        drive(0, 0, 0, 1, 1, 1);
        n_cmp++; if (obs !== C_NONE) begin n_err++; $display("FAIL busy_hold got %h exp %h", obs, C_NONE); end
        tick();
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++; if (obs !== C_SEQ) begin n_err++; $display("FAIL busy_then_nt got %h exp %h", obs, C_SEQ); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL busy_back_run got %h exp %h", obs, C_RUN); end
    endtask

    task automatic test_timeout();
        tick();
        drive(1, 1, 0, 0, 0, 0);
        n_cmp++; if (ifid_flush !== 1'b1) begin n_err++; $display("FAIL to_br_issue flush got %b exp 1", ifid_flush); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0);
            n_cmp++; if (obs !== C_STALL) begin n_err++; $display("FAIL to_wait%0d got %h exp %h", i, obs, C_STALL); end
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_SEQ) begin n_err++; $display("FAIL to_expire got %h exp %h", obs, C_SEQ); end
        n_cmp++; if (br_timeout !== 1'b0) begin n_err++; $display("FAIL to_flag_early got %b exp 0", br_timeout); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL to_back_run got %h exp %h", obs, C_RUN); end
        n_cmp++; if (br_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag_set got %b exp 1", br_timeout); end
    endtask

    task automatic test_hazard_branch();
        tick();
        drive(1, 1, 1, 0, 0, 0);
        n_cmp++; if (obs !== C_STALL) begin n_err++; $display("FAIL hz_br_stall got %h exp %h", obs, C_STALL); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL hz_br_still_run got %h exp %h", obs, C_RUN); end
        n_cmp++; if (br_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag_sticky got %b exp 1", br_timeout); end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        drive(1, 1, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 1, 1, 0);
        n_cmp++; if (obs !== C_NONE) begin n_err++; $display("FAIL rst_wait_no_redirect got %h exp %h", obs, C_NONE); end
        n_cmp++; if (br_timeout !== 1'b0) begin n_err++; $display("FAIL rst_clears_to got %b exp 0", br_timeout); end
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== C_RUN) begin n_err++; $display("FAIL rst_wait_run got %h exp %h", obs, C_RUN); end
`ifdef PIPE_SCHED_PERF_EN
        n_cmp++; if (flush_count !== 16'd0) begin n_err++; $display("FAIL rst_perf got %0d exp 0", flush_count); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_branch = 1'b0; id_hazard = 1'b0;
        ex_br_done = 1'b0; ex_br_taken = 1'b0; mem_busy = 1'b0;
        #1;
        test_reset();
        test_hazard();
        test_branch_taken();
        test_busy_in_wait();
        test_timeout();
        test_hazard_branch();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
